// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: fetch/datapath signal bundle driven and consumed by ctrl_fsm
// master = control unit side, slave = fetch stage / datapath side
interface ctrl_fsm_if;
    logic [5:0]  irOutOpe;
    logic [5:0]  funct;
    logic        aluZero;
    logic        memRdy;
    logic        fecAbl;
    logic [1:0]  pcSrc;
    logic [2:0]  aluCtl;
    logic        aluSrc;
    logic        extOp;
    logic        regDst;
    logic        regWr;
    logic        memRd;
    logic        memWr;
    logic        memToReg;
    logic        illOp;
    logic        halted;
    logic [2:0]  stateOut;
    logic [31:0] insCnt;
    modport master (
        input  irOutOpe, funct, aluZero, memRdy,
        output fecAbl, pcSrc, aluCtl, aluSrc, extOp, regDst, regWr,
               memRd, memWr, memToReg, illOp, halted, stateOut, insCnt
    );
    modport slave (
        output irOutOpe, funct, aluZero, memRdy,
        input  fecAbl, pcSrc, aluCtl, aluSrc, extOp, regDst, regWr,
               memRd, memWr, memToReg, illOp, halted, stateOut, insCnt
    );
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle IF/ID/EXE/MEM/WB control unit that also sequences instruction fetch
// CTRL_HALT_EN: when defined, opcode 111111 parks the FSM in HALT until reset
module ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;
    state_t      r_state, w_nxt;
    logic [5:0]  r_op, r_fn;
    logic [31:0] r_cnt;
    logic        w_rt, w_rok, w_lw, w_sw, w_beq, w_j, w_addi, w_ori, w_hlt, w_ill;
    logic        w_act, w_fec;
    logic [2:0]  w_ralu;

    // all decode works from the copies latched on the IF->ID edge
    assign w_rt   = r_op == 6'b000000;
    assign w_lw   = r_op == 6'b100011;
    assign w_sw   = r_op == 6'b101011;
    assign w_beq  = r_op == 6'b000100;
    assign w_j    = r_op == 6'b000010;
    assign w_addi = r_op == 6'b001000;
    assign w_ori  = r_op == 6'b001101;
    assign w_rok  = r_fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    assign w_ralu = r_fn == 6'b100010 ? 3'b001 :
                    r_fn == 6'b100100 ? 3'b010 :
                    r_fn == 6'b100101 ? 3'b011 :
                    r_fn == 6'b101010 ? 3'b100 : 3'b000;
`ifdef CTRL_HALT_EN
    assign w_hlt       = r_op == 6'b111111;
    assign bus.halted  = r_state == S_HALT;
`else
    assign w_hlt       = 1'b0;
    assign bus.halted  = 1'b0;
`endif
    assign w_ill = !((w_rt & w_rok) | w_lw | w_sw | w_beq | w_j | w_addi | w_ori | w_hlt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_op    <= '0;
            r_fn    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (r_state == S_IF) begin
                r_op <= bus.irOutOpe;
                r_fn <= bus.funct;
            end
            if (w_fec)
                r_cnt <= r_cnt + 32'd1;
        end
    end

    always_comb begin
        w_nxt = S_IF;
        case (r_state)
            S_IF:    w_nxt = S_ID;
            S_ID:    w_nxt = w_ill ? S_IF : w_hlt ? S_HALT : S_EXE;
            S_EXE:   w_nxt = (w_beq | w_j) ? S_IF : (w_lw | w_sw) ? S_MEM : S_WB;
            S_MEM:   w_nxt = !bus.memRdy ? S_MEM : w_lw ? S_WB : S_IF;
            S_WB:    w_nxt = S_IF;
            S_HALT:  w_nxt = S_HALT;
            default: w_nxt = S_IF;
        endcase
    end

    always_comb begin
        w_act = r_state inside {S_ID, S_EXE, S_MEM, S_WB};
        w_fec = ((r_state == S_ID) & w_ill) |
                ((r_state == S_EXE) & (w_beq | w_j)) |
                ((r_state == S_MEM) & w_sw & bus.memRdy) |
                (r_state == S_WB);
        bus.fecAbl   = w_fec;
        bus.pcSrc    = r_state != S_EXE ? 2'b00 :
                       w_j              ? 2'b10 :
                       w_beq            ? {1'b0, bus.aluZero} : 2'b00;
        bus.aluCtl   = !w_act ? 3'b000 :
                       w_rt   ? w_ralu :
                       w_ori  ? 3'b011 :
                       w_beq  ? 3'b001 : 3'b000;
        bus.aluSrc   = w_act & (w_lw | w_sw | w_addi | w_ori);
        bus.extOp    = w_act & (w_lw | w_sw | w_addi | w_beq);
        bus.regDst   = w_act & w_rt;
        bus.regWr    = r_state == S_WB;
        bus.memRd    = (r_state == S_MEM) & w_lw;
        bus.memWr    = (r_state == S_MEM) & w_sw;
        bus.memToReg = (r_state == S_WB) & w_lw;
        bus.illOp    = (r_state == S_ID) & w_ill;
        bus.stateOut = r_state;
        bus.insCnt   = r_cnt;
    end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: randomized instruction stream against an instruction-level reference model
// Stimulus pushes per-instruction expectations; a negedge monitor pops them at each fecAbl
module tb_ctrl_fsm;
    localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6, K_ILL = 7;

    typedef struct {
        int          kind;
        int          k;
        int          len;
        logic [1:0]  pc;
        int          n_rw, n_mr, n_mw, n_m2r, n_ill;
        logic [2:0]  alu;
        logic        asrc, ext, rdst;
        bit          chk, chk_ext;
        logic [31:0] cnt;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    ctrl_fsm_if bus();
    ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    int   n_cmp = 0, n_bad = 0;
    rec_t q[$];
    rec_t mr;
    int   mc = 0, bad_st = 0, bad_pc = 0, a_rw = 0, a_mr = 0, a_mw = 0, a_m2r = 0, a_ill = 0;
    bit   mon_en = 0, pend = 0;
    logic [31:0] pend_cnt, mcnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] outs();
        return {bus.fecAbl, bus.pcSrc, bus.aluCtl, bus.aluSrc, bus.extOp, bus.regDst,
                bus.regWr, bus.memRd, bus.memWr, bus.memToReg, bus.illOp, bus.halted};
    endfunction

    function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn, input int k, input bit z);
        rec_t r;
        r = '{kind: K_ILL, k: k, len: 2, pc: 2'b00, n_rw: 0, n_mr: 0, n_mw: 0, n_m2r: 0, n_ill: 0,
              alu: 3'd0, asrc: 1'b0, ext: 1'b0, rdst: 1'b0, chk: 1'b0, chk_ext: 1'b0, cnt: 32'd0};
        case (op)
            6'h00: case (fn)
                6'h20: begin r.kind = K_R; r.alu = 3'd0; end
                6'h22: begin r.kind = K_R; r.alu = 3'd1; end
                6'h24: begin r.kind = K_R; r.alu = 3'd2; end
                6'h25: begin r.kind = K_R; r.alu = 3'd3; end
                6'h2a: begin r.kind = K_R; r.alu = 3'd4; end
                default: ;
            endcase
            6'h23: r.kind = K_LW;
            6'h2b: r.kind = K_SW;
            6'h04: begin r.kind = K_BEQ; r.alu = 3'd1; end
            6'h02: r.kind = K_J;
            6'h08: r.kind = K_ADDI;
            6'h0d: begin r.kind = K_ORI; r.alu = 3'd3; end
            default: ;
        endcase
        r.rdst    = r.kind == K_R;
        r.asrc    = r.kind inside {K_LW, K_SW, K_ADDI, K_ORI};
        r.ext     = r.kind inside {K_LW, K_SW, K_ADDI, K_BEQ};
        r.chk     = !(r.kind inside {K_J, K_ILL});
        r.chk_ext = r.chk && r.kind != K_R;
        case (r.kind)
            K_R, K_ADDI, K_ORI: begin r.len = 4; r.n_rw = 1; end
            K_LW:  begin r.len = 5 + k; r.n_rw = 1; r.n_mr = k + 1; r.n_m2r = 1; end
            K_SW:  begin r.len = 4 + k; r.n_mw = k + 1; end
            K_BEQ: begin r.len = 3; r.pc = z ? 2'b01 : 2'b00; end
            K_J:   begin r.len = 3; r.pc = 2'b10; end
            default: begin r.len = 2; r.n_ill = 1; end
        endcase
        return r;
    endfunction

    function automatic int exp_state(input int kind, input int k, input int c);
        if (c < 3) return c;
        if (kind == K_LW) return (c <= 3 + k) ? 3 : 4;
        if (kind == K_SW) return 3;
        return 4;
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int k, input bit z);
        rec_t r;
        r = model(op, fn, k, z);
        mcnt++;
        r.cnt = mcnt;
        q.push_back(r);
        for (int c = 0; c < r.len; c++) begin
            bus.irOutOpe = c == 0 ? op : 6'($urandom);
            bus.funct    = c == 0 ? fn : 6'($urandom);
            bus.aluZero  = c == 2 ? z : 1'($urandom);
            bus.memRdy   = (c >= 3 && (r.kind == K_LW || r.kind == K_SW)) ? (c - 3 >= k) : 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (pend) begin
            check("insCnt", bus.insCnt, pend_cnt);
            pend = 0;
        end
        if (mon_en && q.size() > 0) begin
            mr = q[0];
            if (32'(bus.stateOut) != 32'(exp_state(mr.kind, mr.k, mc))) bad_st++;
            if (bus.pcSrc != 2'b00 && !bus.fecAbl) bad_pc++;
            a_rw += int'(bus.regWr);
            a_mr += int'(bus.memRd);
            a_mw += int'(bus.memWr);
            a_m2r += int'(bus.memToReg);
            a_ill += int'(bus.illOp);
            if (mc == 0) check("if_idle", outs(), 15'd0);
            if (mc == 1 && mr.chk) begin
                check("aluCtl_id", bus.aluCtl, mr.alu);
                check("aluSrc_id", bus.aluSrc, mr.asrc);
                check("regDst_id", bus.regDst, mr.rdst);
                if (mr.chk_ext) check("extOp_id", bus.extOp, mr.ext);
            end
            if (bus.fecAbl) begin
                check("len", mc + 1, mr.len);
                check("pcSrc", bus.pcSrc, mr.pc);
                check("regWr_cnt", a_rw, mr.n_rw);
                check("memRd_cnt", a_mr, mr.n_mr);
                check("memWr_cnt", a_mw, mr.n_mw);
                check("memToReg_cnt", a_m2r, mr.n_m2r);
                check("illOp_cnt", a_ill, mr.n_ill);
                check("state_trace", bad_st, 0);
                check("pcSrc_idle", bad_pc, 0);
                if (mr.chk) check("aluCtl_hold", bus.aluCtl, mr.alu);
                void'(q.pop_front());
                pend = 1;
                pend_cnt = mr.cnt;
                mc = 0;
                {bad_st, bad_pc, a_rw, a_mr, a_mw, a_m2r, a_ill} = '0;
            end else if (mc >= 40) begin
                check("fecAbl_timeout", 1, 0);
                void'(q.pop_front());
                mc = 0;
                {bad_st, bad_pc, a_rw, a_mr, a_mw, a_m2r, a_ill} = '0;
            end else
                mc++;
        end
    end

    initial begin
        logic [5:0] op, fn;
        rst = 1'b1;
        bus.irOutOpe = '0;
        bus.funct = '0;
        bus.aluZero = 1'b0;
        bus.memRdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", outs(), 15'd0);
        check("rst_state", bus.stateOut, 3'd0);
        check("rst_insCnt", bus.insCnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1;
        run_instr(6'h00, 6'h20, 0, 1'b0);
        run_instr(6'h23, 6'h00, 3, 1'b0);
        run_instr(6'h04, 6'h00, 0, 1'b1);
        run_instr(6'h04, 6'h00, 0, 1'b0);
        run_instr(6'h15, 6'h00, 0, 1'b0);
        run_instr(6'h00, 6'h07, 0, 1'b0);
`ifndef CTRL_HALT_EN
        run_instr(6'h3f, 6'h00, 0, 1'b0);
`endif
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 10))
                0, 1, 2: op = 6'h00;
                3: op = 6'h23;
                4: op = 6'h2b;
                5: op = 6'h04;
                6: op = 6'h02;
                7: op = 6'h08;
                8: op = 6'h0d;
                9: op = 6'h3f;
                default: op = 6'($urandom);
            endcase
`ifdef CTRL_HALT_EN
            if (op == 6'h3f) op = 6'h15;
`endif
            case ($urandom_range(0, 5))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h2a;
                default: fn = 6'($urandom);
            endcase
            run_instr(op, fn, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        mon_en = 0;
        // sw stalled in MEM, then reset mid-access
        bus.irOutOpe = 6'h2b;
        bus.memRdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("sw_in_mem", {bus.stateOut, bus.memWr}, {3'd3, 1'b1});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_state", bus.stateOut, 3'd0);
        check("rst_mem_memWr", bus.memWr, 1'b0);
        check("rst_mem_insCnt", bus.insCnt, 32'd0);
`ifdef CTRL_HALT_EN
        @(posedge clk); #1;
        rst = 1'b0;
        bus.irOutOpe = 6'h3f;
        bus.memRdy = 1'b1;
        @(posedge clk); #1;
        bus.irOutOpe = 6'h00;
        @(posedge clk); #1;
        repeat (20) begin
            @(negedge clk);
            check("halt_park", {bus.stateOut, bus.halted, bus.fecAbl, bus.insCnt}, {3'd5, 1'b1, 1'b0, 32'd0});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("halt_rst", {bus.stateOut, bus.halted}, {3'd0, 1'b0});
`endif
        repeat (2) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
